// File: rtl/rf_scoreboard_if.sv
// Issue and write-back bus between the
// decode/issue stage and the scoreboard.
interface rf_scoreboard_if;
  logic        issue_valid;
  logic [31:0] issue_inst;
  logic        issue_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  modport master (
    output issue_valid, issue_inst,
    output wb_valid, wb_rd, flush,
    input  issue_stall
  );

  modport slave (
    input  issue_valid, issue_inst,
    input  wb_valid, wb_rd, flush,
    output issue_stall
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: per-register pending
// write counts, RAW/saturation issue stall.
module rf_scoreboard #(
  parameter int CNT_W  = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 nrst,
  rf_scoreboard_if.slave       bus,
  output logic [31:0]          busy_vec,
  output logic                 wb_err
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];
  logic [31:0]      busy_nxt;

  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd;
  logic       use_rs1, use_rs2, use_rd;

  assign opc = bus.issue_inst[6:0];
  assign rd  = bus.issue_inst[11:7];
  assign rs1 = bus.issue_inst[19:15];
  assign rs2 = bus.issue_inst[24:20];

  logic unused_bits;
  assign unused_bits = ^{bus.issue_inst[31:25],
                         bus.issue_inst[14:12]};

  // Which register fields the opcode really uses
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    unique case (1'b1)
      opc == OP_R:   {use_rs1, use_rs2, use_rd} = 3'b111;
      opc == OP_I:   {use_rs1, use_rs2, use_rd} = 3'b101;
      opc == OP_B:   {use_rs1, use_rs2, use_rd} = 3'b110;
      opc == OP_JAL: {use_rs1, use_rs2, use_rd} = 3'b001;
      opc == OP_JLR: {use_rs1, use_rs2, use_rd} = 3'b101;
      opc == OP_LD:  {use_rs1, use_rs2, use_rd} = 3'b101;
      opc == OP_ST:  {use_rs1, use_rs2, use_rd} = 3'b110;
      default: ;
    endcase
  end

  logic [CNT_W-1:0] c1, c2, cd, cw;
  logic byp1, byp2, busy1, busy2, sat;
  logic stall, inc, dec, err_set;

  assign c1 = cnt[rs1];
  assign c2 = cnt[rs2];
  assign cd = cnt[rd];
  assign cw = cnt[bus.wb_rd];

  assign byp1 = BYPASS && c1 == CNT_ONE &&
                bus.wb_valid && bus.wb_rd == rs1;
  assign byp2 = BYPASS && c2 == CNT_ONE &&
                bus.wb_valid && bus.wb_rd == rs2;

  assign busy1 = use_rs1 && rs1 != 5'd0 &&
                 c1 != '0 && !byp1;
  assign busy2 = use_rs2 && rs2 != 5'd0 &&
                 c2 != '0 && !byp2;
  // Pre-edge count: a retiring max register still stalls
  assign sat   = use_rd && rd != 5'd0 &&
                 cd == CNT_MAX;

  assign stall = bus.issue_valid &&
                 (bus.flush || busy1 || busy2 || sat);
  assign bus.issue_stall = stall;

  assign inc = bus.issue_valid && !stall &&
               use_rd && rd != 5'd0;
  assign dec = bus.wb_valid && !bus.flush &&
               bus.wb_rd != 5'd0 && cw != '0;
  assign err_set = bus.wb_valid && !bus.flush &&
                   bus.wb_rd != 5'd0 && cw == '0;

  logic [31:0] inc_vec, dec_vec;
  assign inc_vec = {31'b0, inc} << rd;
  assign dec_vec = {31'b0, dec} << bus.wb_rd;

  // Next counts: flush clears, same-reg inc+dec nets out
  always_comb begin
    busy_nxt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt_nxt[i] = cnt[i];
      if (bus.flush)
        cnt_nxt[i] = '0;
      else if (inc_vec[i] && !dec_vec[i])
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      else if (dec_vec[i] && !inc_vec[i])
        cnt_nxt[i] = cnt[i] - CNT_ONE;
      busy_nxt[i] = |cnt_nxt[i];
    end
  end

  // State registers; wb_err is sticky until reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 32; i++)
        cnt[i] <= '0;
      busy_vec <= '0;
      wb_err   <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      busy_vec <= busy_nxt;
      wb_err   <= wb_err | err_set;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: vector table
// plus reset, flush and no-bypass sequences.
module tb_rf_scoreboard;

  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPJ = 7'b1101111;
  localparam logic [6:0] OPS = 7'b0100011;

  logic clk;
  logic nrst;
  logic [31:0] busy1, busy0;
  logic err1, err0;

  rf_scoreboard_if sb1 ();
  rf_scoreboard_if sb0 ();

  rf_scoreboard #(.CNT_W(2), .BYPASS(1'b1)) dut (
    .clk(clk), .nrst(nrst), .bus(sb1),
    .busy_vec(busy1), .wb_err(err1)
  );

  rf_scoreboard #(.CNT_W(2), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .nrst(nrst), .bus(sb0),
    .busy_vec(busy0), .wb_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] inst;
    logic        wv;
    logic [4:0]  wrd;
    logic        fl;
    logic        st;
    logic [31:0] busy;
    logic        err;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] enc(
    logic [6:0] op, logic [4:0] rd,
    logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, op};
  endfunction

  function automatic vec_t mk(
    logic iv, logic [31:0] inst, logic wv,
    logic [4:0] wrd, logic fl, logic st,
    logic [31:0] busy, logic err);
    vec_t v;
    v.iv = iv; v.inst = inst; v.wv = wv;
    v.wrd = wrd; v.fl = fl; v.st = st;
    v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic chk(string nm,
                     logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, got, exp);
    end
  endtask

  task automatic drv1(logic iv, logic [31:0] inst,
                      logic wv, logic [4:0] wrd,
                      logic fl);
    sb1.issue_valid = iv;
    sb1.issue_inst  = inst;
    sb1.wb_valid    = wv;
    sb1.wb_rd       = wrd;
    sb1.flush       = fl;
  endtask

  task automatic drv0(logic iv, logic [31:0] inst,
                      logic wv, logic [4:0] wrd);
    sb0.issue_valid = iv;
    sb0.issue_inst  = inst;
    sb0.wb_valid    = wv;
    sb0.wb_rd       = wrd;
    sb0.flush       = 1'b0;
  endtask

  initial begin
    // iv inst wv wrd fl | stall busy err
    tv.push_back(mk(1, 32'h002082B3, 0, 0, 0,
                    0, 32'h20, 0));
    tv.push_back(mk(1, enc(OPI, 6, 5, 0), 0, 0, 0,
                    1, 32'h20, 0));
    tv.push_back(mk(1, enc(OPI, 6, 5, 0), 0, 0, 0,
                    1, 32'h20, 0));
    tv.push_back(mk(1, enc(OPI, 6, 5, 0), 1, 5, 0,
                    0, 32'h40, 0));
    tv.push_back(mk(1, enc(OPJ, 0, 0, 0), 0, 0, 0,
                    0, 32'h40, 0));
    tv.push_back(mk(1, enc(OPI, 7, 0, 0), 0, 0, 0,
                    0, 32'hC0, 0));
    tv.push_back(mk(1, enc(OPI, 7, 0, 0), 0, 0, 0,
                    0, 32'hC0, 0));
    tv.push_back(mk(1, enc(OPI, 7, 0, 0), 0, 0, 0,
                    0, 32'hC0, 0));
    tv.push_back(mk(1, enc(OPI, 7, 0, 0), 1, 7, 0,
                    1, 32'hC0, 0));
    tv.push_back(mk(1, enc(OPI, 7, 0, 0), 0, 0, 0,
                    0, 32'hC0, 0));
    tv.push_back(mk(1, enc(OPI, 7, 0, 0), 0, 0, 0,
                    1, 32'hC0, 0));
    tv.push_back(mk(0, 32'h0, 1, 0, 0,
                    0, 32'hC0, 0));
    tv.push_back(mk(0, 32'h0, 1, 1, 0,
                    0, 32'hC0, 1));
    tv.push_back(mk(0, 32'h0, 1, 6, 0,
                    0, 32'h80, 1));
    tv.push_back(mk(1, enc(OPR, 8, 7, 0), 0, 0, 0,
                    1, 32'h80, 1));
    tv.push_back(mk(1, enc(OPI, 4, 0, 0), 0, 0, 0,
                    0, 32'h90, 1));
    tv.push_back(mk(1, enc(OPS, 0, 8, 4), 0, 0, 0,
                    1, 32'h90, 1));
    tv.push_back(mk(1, enc(7'h7F, 4, 4, 4), 0, 0, 0,
                    0, 32'h90, 1));
    tv.push_back(mk(1, enc(OPB, 0, 0, 7), 0, 0, 0,
                    1, 32'h90, 1));
    tv.push_back(mk(1, enc(OPI, 9, 7, 0), 1, 7, 0,
                    1, 32'h90, 1));
    tv.push_back(mk(1, enc(OPI, 3, 0, 0), 1, 4, 1,
                    1, 32'h0, 1));
    tv.push_back(mk(1, enc(OPJ, 1, 0, 0), 0, 0, 0,
                    0, 32'h2, 1));

    nrst = 1'b0;
    drv0(0, 32'h0, 0, 0);
    drv1(1, 32'h002082B3, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy1, 32'h0);
    chk("rst err", {31'b0, err1}, 32'h0);
    chk("rst stall", {31'b0, sb1.issue_stall}, 32'h0);
    chk("rst busy nb", busy0, 32'h0);

    @(negedge clk);
    drv1(0, 32'h0, 0, 0, 0);
    nrst = 1'b1;

    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      drv1(tv[k].iv, tv[k].inst, tv[k].wv,
           tv[k].wrd, tv[k].fl);
      #1;
      chk($sformatf("v%0d stall", k),
          {31'b0, sb1.issue_stall},
          {31'b0, tv[k].st});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d busy", k),
          busy1, tv[k].busy);
      chk($sformatf("v%0d err", k),
          {31'b0, err1}, {31'b0, tv[k].err});
    end

    // async reset mid-operation
    @(negedge clk);
    drv1(1, enc(OPI, 10, 0, 0), 0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre-rst busy", busy1, 32'h402);
    @(negedge clk);
    drv1(0, 32'h0, 0, 0, 0);
    #2;
    nrst = 1'b0;
    #1;
    chk("async busy", busy1, 32'h0);
    chk("async err", {31'b0, err1}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;

    // flush clears counts; later wb errors
    @(negedge clk);
    drv1(1, enc(OPI, 3, 0, 0), 0, 0, 0);
    @(negedge clk);
    drv1(1, enc(OPI, 9, 0, 0), 0, 0, 0);
    @(posedge clk);
    #1;
    chk("fl busy pre", busy1, 32'h208);
    @(negedge clk);
    drv1(1, enc(OPI, 11, 0, 0), 0, 0, 1);
    #1;
    chk("fl stall", {31'b0, sb1.issue_stall}, 32'h1);
    @(posedge clk);
    #1;
    chk("fl busy", busy1, 32'h0);
    chk("fl err", {31'b0, err1}, 32'h0);
    @(negedge clk);
    drv1(0, 32'h0, 1, 3, 0);
    @(posedge clk);
    #1;
    chk("fl wb err", {31'b0, err1}, 32'h1);
    chk("fl wb busy", busy1, 32'h0);
    @(negedge clk);
    drv1(0, 32'h0, 0, 0, 0);

    // no-bypass instance: release one cycle later
    @(negedge clk);
    drv0(1, 32'h002082B3, 0, 0);
    @(posedge clk);
    #1;
    chk("nb busy1", busy0, 32'h20);
    @(negedge clk);
    drv0(1, enc(OPI, 6, 5, 0), 1, 5);
    #1;
    chk("nb stall", {31'b0, sb0.issue_stall}, 32'h1);
    @(posedge clk);
    #1;
    chk("nb busy2", busy0, 32'h0);
    @(negedge clk);
    drv0(1, enc(OPI, 6, 5, 0), 0, 0);
    #1;
    chk("nb go", {31'b0, sb0.issue_stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("nb busy3", busy0, 32'h40);
    chk("nb err", {31'b0, err0}, 32'h0);
    @(negedge clk);
    drv0(0, 32'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-file scoreboard and issue controller for the multi-cycle pipelined RISC-V core. It decodes the source and destination register fields of the instruction at the issue stage and tracks in-flight writes to each architectural register. It stalls issue on RAW hazards and on write-count overflow, and releases registers as results retire through the single write-back port. It sits between the decode/issue stage and the register file's write-back path.

## Interface

- CNT_W, default 2: width of the per-register pending-write counter; the maximum in-flight writes to one register is 2^CNT_W-1.
- BYPASS, default 1: when 1, a source retiring in the current cycle is treated as ready because the datapath forwards write-back data; when 0, no forwarding is assumed.
- clk, input, 1: clock, rising-edge.
- nrst, input, 1: reset, asynchronous, active-low.
- issue_valid, input, 1: the instruction on issue_inst is presented for issue.
- issue_inst, input, 32: raw instruction; rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0].
- issue_stall, output, 1: combinational; the instruction must not issue this cycle.
- wb_valid, input, 1: one register write retires this cycle.
- wb_rd, input, 5: destination register of the retiring write.
- flush, input, 1: squash all in-flight instructions.
- busy_vec, output, 32: registered; bit i is 1 when the count for register i is nonzero. Bit 0 is always 0.
- wb_err, output, 1: sticky flag. It sets when write-back targets a register whose count is 0.

## Operation

- Register usage by opcode:
  - R-type 0110011: rs1, rs2, rd.
  - ADDI-class 0010011: rs1, rd.
  - Branch 1100011: rs1, rs2.
  - JAL 1101111: rd.
  - JALR 1100111: rs1, rd.
  - Load 0000011: rs1, rd.
  - Store 0100011: rs1, rs2.
  - Any other opcode uses no registers and never stalls.
- x0 is never busy and is never counted, whether as source or destination.
- A source is busy when cnt[rs] != 0. When BYPASS=1 there is one exception: the source is not busy if cnt[rs]==1 and wb_valid && wb_rd==rs in the same cycle.
- issue_stall = issue_valid && (flush || rs1 used and busy || rs2 used and busy || rd used, rd!=0 and cnt[rd]==2^CNT_W-1).
- Accept = issue_valid && !issue_stall. On accept with rd used and rd!=0, cnt[rd] increments.
- On wb_valid with wb_rd!=0 and cnt[wb_rd]!=0, cnt[wb_rd] decrements.
- On wb_valid with wb_rd!=0 and cnt[wb_rd]==0, the count stays 0 and wb_err sets.
- Accept and write-back to the same rd in one cycle: net count unchanged. The saturation check uses the pre-edge count, so a register at max stalls even if it is retiring this cycle.
- Flush has priority over everything else. All counts clear at the next edge, and issue and write-back in the flush cycle are ignored. wb_err is not affected by flush.
- Counts never wrap: increment is blocked by the saturation stall, and decrement is blocked at 0.

## Timing

- Reset (nrst low, asynchronous): all counts 0, busy_vec=0, wb_err=0. issue_stall then depends only on the inputs and the cleared state.
- issue_stall is combinational from the current counts and issue_inst, wb_valid, wb_rd and flush in the same cycle. It has no registered latency.
- Counts, busy_vec and wb_err update on the rising edge of clk. busy_vec reflects the new counts one cycle after an accept or write-back.
- Write-back release latency:
  - BYPASS=1: a dependent instruction can issue in the same cycle as the producer's write-back.
  - BYPASS=0: it can issue in the cycle after.
- Reset asserted mid-operation discards all pending state immediately. In-flight results arriving afterwards set wb_err.

## Test plan

- Reset, then issue add x5,x1,x2 (0x002082B3) → no stall, busy_vec=0x00000020 next cycle. Then issue addi x6,x5,1 → issue_stall=1 until wb_valid with wb_rd=5.
- BYPASS=1, cnt[5]=1: present addi x6,x5,1 together with wb_valid, wb_rd=5 → issue_stall=0 that cycle. Next cycle busy_vec bit5=0 and bit6=1. With BYPASS=0 the same stimulus gives issue_stall=1.
- CNT_W=2: issue three writes to x7 with no write-back → the fourth stalls. Add a write-back of x7 in the same cycle as the fourth → it still stalls. The next cycle it issues and cnt[7] stays 3.
- Write-back to x0, or to a register with count 0 → counts unchanged; wb_err=1 for the latter only, and it stays set until reset.
- Set counts on x3 and x9, then assert flush together with issue_valid → issue_stall=1, busy_vec=0 next cycle, and a later write-back to x3 sets wb_err.
- Store sw x4,0(x8) with x4 busy → stall. JAL x0 → never stalls and busy_vec is unchanged. Assert nrst low mid-sequence → busy_vec=0 and wb_err=0 asynchronously.
